// File: rtl/gates_sweep_ctrl_if.sv
// Operand/result bus between the gate-sweep sequencer (master) and its host plus the gate units (slave).
// Carries shared operands, the three packed gate outputs, start and the status/result fields.
interface gates_sweep_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     a_out;
    logic [WIDTH-1:0]     b_out;
    logic [5*WIDTH-1:0]   y_sv;
    logic [5*WIDTH-1:0]   y_v;
    logic [5*WIDTH-1:0]   y_vhd;
    logic                 busy;
    logic                 done;
    logic [5:0]           err_count;
    logic [2:0]           fail_mask;
    logic                 first_fail_valid;
    logic [WIDTH:0]       first_fail_step;

    modport master (
        input  start, y_sv, y_v, y_vhd,
        output a_out, b_out, busy, done, err_count, fail_mask,
               first_fail_valid, first_fail_step
    );

    modport slave (
        output start, y_sv, y_v, y_vhd,
        input  a_out, b_out, busy, done, err_count, fail_mask,
               first_fail_valid, first_fail_step
    );
endinterface

// File: rtl/gates_sweep_ctrl.sv
// Staircase sweep of a/b into three gate implementations, each checked against a golden model.
// 2^(WIDTH+1)-1 vectors x (SETTLE_CYCLES+1) busy cycles, then a one-cycle done; start ignored unless IDLE.
module gates_sweep_ctrl #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    gates_sweep_ctrl_if.master    bus
);
    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH:0] LAST_STEP   = {{WIDTH{1'b1}}, 1'b0};
    localparam logic [5:0]     ERR_MAX     = 6'h3F;

    state_t             state_q, state_d;
    logic [WIDTH:0]     step_q, step_d, step_nx;
    logic [SW-1:0]      settle_q, settle_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [5:0]         err_q, err_d;
    logic [2:0]         mask_q, mask_d;
    logic               ffv_q, ffv_d;
    logic [WIDTH:0]     ffs_q, ffs_d;
    logic [5*WIDTH-1:0] gold;
    logic [2:0]         mis;

    // (s+1)>>1 rewritten as (s>>1) + s[0] so no carry bit is left unused
    function automatic logic [WIDTH-1:0] op_a(input logic [WIDTH:0] s);
        return s[WIDTH:1] + {{(WIDTH-1){1'b0}}, s[0]};
    endfunction

    function automatic logic [WIDTH-1:0] op_b(input logic [WIDTH:0] s);
        return s[WIDTH:1];
    endfunction

    assign gold = {~(a_q | b_q), ~(a_q & b_q), a_q ^ b_q, a_q | b_q, a_q & b_q};
    assign mis  = {bus.y_vhd != gold, bus.y_v != gold, bus.y_sv != gold};

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        step_nx  = step_q + 1'b1;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        err_d    = err_q;
        mask_d   = mask_q;
        ffv_d    = ffv_q;
        ffs_d    = ffs_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    err_d    = '0;
                    mask_d   = '0;
                    ffv_d    = 1'b0;
                    ffs_d    = '0;
                    step_d   = '0;
                    settle_d = '0;
                    a_d      = op_a('0);
                    b_d      = op_b('0);
                    state_d  = APPLY;
                end
            end
            APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            CHECK: begin
                mask_d = mask_q | mis;
                if (|mis) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 6'd1;
                    end
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffs_d = step_q;
                    end
                end
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end else begin
                    step_d   = step_nx;
                    a_d      = op_a(step_nx);
                    b_d      = op_b(step_nx);
                    settle_d = '0;
                    state_d  = APPLY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            settle_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            err_q    <= '0;
            mask_q   <= '0;
            ffv_q    <= 1'b0;
            ffs_q    <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            err_q    <= err_d;
            mask_q   <= mask_d;
            ffv_q    <= ffv_d;
            ffs_q    <= ffs_d;
        end
    end

    assign bus.a_out            = a_q;
    assign bus.b_out            = b_q;
    assign bus.busy             = (state_q == APPLY) || (state_q == CHECK);
    assign bus.done             = (state_q == DONE);
    assign bus.err_count        = err_q;
    assign bus.fail_mask        = mask_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_step  = ffs_q;
endmodule

// File: tb/tb_gates_sweep_ctrl.sv
// Bench for gates_sweep_ctrl: behavioural gate units with injectable faults, two DUTs (settle 1 and 3),
// expected sweep results queued at start and popped by per-DUT monitors on done.
module tb_gates_sweep_ctrl;
    typedef struct {
        int err;
        int mask;
        int ffv;
        int ffs;
        int busy;
    } exp_t;

    logic clk;
    logic reset;
    logic f0_vhd_y3, f0_sv_y4b0, f1_vhd_y3;

    int n_pass  = 0;
    int n_total = 0;
    exp_t q0[$];
    exp_t q1[$];
    int bc0 = 0, bc1 = 0;
    int opbad0 = 0, opbad1 = 0;
    int dn0 = 0, dn1 = 0;

    gates_sweep_ctrl_if #(.WIDTH(4)) if0();
    gates_sweep_ctrl_if #(.WIDTH(4)) if1();

    gates_sweep_ctrl #(.WIDTH(4), .SETTLE_CYCLES(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    gates_sweep_ctrl #(.WIDTH(4), .SETTLE_CYCLES(3)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    function automatic logic [19:0] gates(input logic [3:0] a, input logic [3:0] b);
        return {~(a | b), ~(a & b), a ^ b, a | b, a & b};
    endfunction

    assign if0.y_sv  = gates(if0.a_out, if0.b_out) | (f0_sv_y4b0 ? 20'h01000 : 20'h0);
    assign if0.y_v   = gates(if0.a_out, if0.b_out);
    assign if0.y_vhd = gates(if0.a_out, if0.b_out) & ~(f0_vhd_y3 ? 20'h00F00 : 20'h0);
    assign if1.y_sv  = gates(if1.a_out, if1.b_out);
    assign if1.y_v   = gates(if1.a_out, if1.b_out);
    assign if1.y_vhd = gates(if1.a_out, if1.b_out) & ~(f1_vhd_y3 ? 20'h00F00 : 20'h0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic exp_t mk(input int e, input int m, input int v, input int s, input int b);
        exp_t x;
        x.err = e; x.mask = m; x.ffv = v; x.ffs = s; x.busy = b;
        return x;
    endfunction

    // Monitors: count busy cycles, check operands against the staircase, pop expectations on done
    always @(negedge clk) begin
        int s;
        exp_t e;
        if (reset) begin
            bc0 = 0; opbad0 = 0;
        end else begin
            if (if0.busy) begin
                s = bc0 / 2;
                bc0++;
                if (if0.a_out != 4'((s + 1) >> 1) || if0.b_out != 4'(s >> 1)) opbad0++;
            end
            if (if0.done) begin
                dn0++;
                chk("dut0_done_expected", int'(q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    chk("dut0_err_count", int'(if0.err_count), e.err);
                    chk("dut0_fail_mask", int'(if0.fail_mask), e.mask);
                    chk("dut0_ff_valid", int'(if0.first_fail_valid), e.ffv);
                    chk("dut0_ff_step", int'(if0.first_fail_step), e.ffs);
                    chk("dut0_busy_cycles", bc0, e.busy);
                    chk("dut0_operand_seq_errors", opbad0, 0);
                end
                bc0 = 0; opbad0 = 0;
            end
        end
    end

    always @(negedge clk) begin
        int s;
        exp_t e;
        if (reset) begin
            bc1 = 0; opbad1 = 0;
        end else begin
            if (if1.busy) begin
                s = bc1 / 4;
                bc1++;
                if (if1.a_out != 4'((s + 1) >> 1) || if1.b_out != 4'(s >> 1)) opbad1++;
            end
            if (if1.done) begin
                dn1++;
                chk("dut1_done_expected", int'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    chk("dut1_err_count", int'(if1.err_count), e.err);
                    chk("dut1_fail_mask", int'(if1.fail_mask), e.mask);
                    chk("dut1_ff_valid", int'(if1.first_fail_valid), e.ffv);
                    chk("dut1_ff_step", int'(if1.first_fail_step), e.ffs);
                    chk("dut1_busy_cycles", bc1, e.busy);
                    chk("dut1_operand_seq_errors", opbad1, 0);
                end
                bc1 = 0; opbad1 = 0;
            end
        end
    end

    task automatic pulse_start(input int which);
        @(posedge clk); #1;
        if (which == 0) if0.start = 1'b1; else if1.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        if1.start = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        int d0, n;
        d0 = (which == 0) ? dn0 : dn1;
        n = 0;
        while (((which == 0) ? dn0 : dn1) == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("wait_done_in_budget", ((which == 0) ? dn0 : dn1) - d0, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_a"}, int'(if0.a_out), 0);
        chk({tag, "_b"}, int'(if0.b_out), 0);
        chk({tag, "_busy"}, int'(if0.busy), 0);
        chk({tag, "_done"}, int'(if0.done), 0);
        chk({tag, "_err"}, int'(if0.err_count), 0);
        chk({tag, "_mask"}, int'(if0.fail_mask), 0);
        chk({tag, "_ffv"}, int'(if0.first_fail_valid), 0);
        chk({tag, "_ffs"}, int'(if0.first_fail_step), 0);
    endtask

    initial begin
        int d_before;
        reset = 1'b1;
        if0.start = 1'b0;
        if1.start = 1'b0;
        f0_vhd_y3 = 1'b0; f0_sv_y4b0 = 1'b0; f1_vhd_y3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("por");
        reset = 1'b0;

        // Clean sweep at defaults
        q0.push_back(mk(0, 0, 0, 0, 62));
        pulse_start(0);
        wait_done(0, 200);

        // VHDL y3 stuck at 0: every odd step mismatches
        f0_vhd_y3 = 1'b1;
        q0.push_back(mk(15, 3'b100, 1, 1, 62));
        pulse_start(0);
        wait_done(0, 200);

        // SV y4 bit0 stuck at 1: only (n,n) with n odd mismatches
        f0_vhd_y3 = 1'b0;
        f0_sv_y4b0 = 1'b1;
        q0.push_back(mk(8, 3'b001, 1, 2, 62));
        pulse_start(0);
        wait_done(0, 200);

        // Restart attempt at step 5 must be ignored
        f0_sv_y4b0 = 1'b0;
        f0_vhd_y3 = 1'b1;
        q0.push_back(mk(15, 3'b100, 1, 1, 62));
        pulse_start(0);
        repeat (9) @(posedge clk);
        pulse_start(0);
        wait_done(0, 200);

        // Reset at step 10 aborts without done
        d_before = dn0;
        pulse_start(0);
        repeat (19) @(posedge clk);
        #1;
        chk("pre_reset_busy", int'(if0.busy), 1);
        chk("pre_reset_err_nonzero", int'(if0.err_count != 0), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_reset_state("midreset");
        repeat (80) @(posedge clk);
        chk("no_done_after_abort", dn0 - d_before, 0);
        f0_vhd_y3 = 1'b0;
        q0.push_back(mk(0, 0, 0, 0, 62));
        pulse_start(0);
        wait_done(0, 200);

        // SETTLE_CYCLES=3: faulty sweep, then clean sweep clears results
        f1_vhd_y3 = 1'b1;
        q1.push_back(mk(15, 3'b100, 1, 1, 124));
        pulse_start(1);
        wait_done(1, 400);
        f1_vhd_y3 = 1'b0;
        q1.push_back(mk(0, 0, 0, 0, 124));
        pulse_start(1);
        chk("settle3_busy_after_start", int'(if1.busy), 1);
        chk("settle3_err_cleared", int'(if1.err_count), 0);
        chk("settle3_mask_cleared", int'(if1.fail_mask), 0);
        chk("settle3_ffv_cleared", int'(if1.first_fail_valid), 0);
        wait_done(1, 400);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/gates_sweep_ctrl.md
Name: gates_sweep_ctrl

Overview:
Sequencer and checker for the 4-bit logic-gate unit (y1=a&b, y2=a|b, y3=a^b, y4=~(a&b), y5=~(a|b)), which exists in three implementations: SV, Verilog and VHDL.
- Drives one shared a/b operand pair into all three implementations and steps through the staircase sweep (0,0),(1,0),(1,1),(2,1)…(F,F).
- Compares every implementation against an internal golden model and reports the result.
- Replaces the manual stimulus bench with a synthesizable self-check for board bring-up.

Parameters:
WIDTH, 4, operand width of a/b and of each gate output.
SETTLE_CYCLES, 1, cycles operands are held before sampling; legal range ≥1.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  begin sweep; sampled only in IDLE.
a_out  out  WIDTH  operand a to all three implementations.
b_out  out  WIDTH  operand b to all three implementations.
y_sv  in  5*WIDTH  SV outputs packed {y5,y4,y3,y2,y1}.
y_v  in  5*WIDTH  Verilog outputs, same packing.
y_vhd  in  5*WIDTH  VHDL outputs, same packing.
busy  out  1  high in APPLY/CHECK.
done  out  1  one-cycle pulse at sweep end.
err_count  out  6  number of vectors with any mismatch; saturates at 63.
fail_mask  out  3  sticky per-implementation mismatch {vhd,v,sv}.
first_fail_valid  out  1  first_fail_step holds a captured step.
first_fail_step  out  WIDTH+1  step index of the first failing vector.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: a_out=0, b_out=0, busy=0, done=0, err_count=0, fail_mask=0, first_fail_valid=0, first_fail_step=0, state=IDLE.
- Reset asserted mid-sweep aborts the sweep immediately, without a done pulse.
- Step counter s runs 0..2^(WIDTH+1)-2 (31 vectors at WIDTH=4).
  - a_out=(s+1)>>1, b_out=s>>1.
  - So s=0 → (0,0), s=1 → (1,0), s=2 → (1,1), s=30 → (F,F).
- Golden model is computed combinationally from the registered a_out/b_out.
- FSM states:
  - IDLE: busy=0. start=1 → clear err_count, fail_mask, first_fail_*; s=0; load a_out/b_out; go to APPLY.
  - APPLY: hold operands for SETTLE_CYCLES cycles (settle counter), then go to CHECK.
  - CHECK: one cycle. Compare y_sv, y_v and y_vhd against golden over all 5*WIDTH bits.
    - OR the per-implementation mismatch bits into fail_mask.
    - If any implementation mismatches: increment err_count (saturating at 63). If first_fail_valid=0, capture s into first_fail_step and set first_fail_valid.
    - If s is not the last step: s+1, load the new operands, go to APPLY.
    - Else go to DONE.
  - DONE: done=1, busy=0 for one cycle, then IDLE.
- Operands stay at their last values in DONE and IDLE.
- Results stay stable until the next accepted start.
- Latency: start sampled at edge k → busy from cycle k+1 → done high during the cycle after 31*(SETTLE_CYCLES+1) busy cycles (62 at defaults).
- start while busy or in DONE is ignored, with no restart and no effect on results.
- start held high in IDLE after DONE begins a new sweep and clears results.
- Inputs are sampled only in CHECK; glitches during APPLY are irrelevant.

Test Plan:
1. All three implementations correct, defaults, pulse start → busy for exactly 62 cycles, a/b visit (0,0),(1,0),(1,1)…(F,F), done pulses once, err_count=0, fail_mask=000, first_fail_valid=0.
2. VHDL y3 forced to 0 → err_count=15 (every odd step, where a^b≠0), fail_mask=100, first_fail_step=1 (a=1,b=0).
3. SV y4 bit0 forced to 1 → err_count=8 (steps (n,n) with n odd), fail_mask=001, first_fail_step=2.
4. Pulse start again at step 5 of a sweep with fault 2 active → sweep continues unaffected, final results as in scenario 2, single done pulse.
5. Assert reset for one cycle at step 10 → next cycle all outputs at reset values and state IDLE with no done; a following start gives a full clean sweep.
6. SETTLE_CYCLES=3, faults removed after a faulty sweep, start → 124 busy cycles, err_count/fail_mask/first_fail_valid cleared at start and end at 0/000/0.
